// File: rtl/io_bus_master_if.sv
// Command, response and register-port signals shared by io_bus_master and
// its environment. The master modport is the block's own view.
interface io_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_data;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  logic       bus_en;
  logic       bus_we_n;
  logic [2:0] bus_a;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_oe;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready,
    output bus_en, bus_we_n, bus_a, bus_wdata,
    input  bus_rdata, bus_oe
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready,
    input  bus_en, bus_we_n, bus_a, bus_wdata,
    output bus_rdata, bus_oe
  );
endinterface

// File: rtl/io_bus_master.sv
// Register-port bus master: turns write / read / set-bits / clear-bits
// commands into one-cycle strobes on an 8-bit register port, waits a bounded
// number of edges for read data and returns one response per command.
// All outputs are registered; the bus strobe is computed one edge ahead.
module io_bus_master #(
  parameter int TIMEOUT = 4
) (
  input logic            clk,
  input logic            rst_n,
  io_bus_master_if.master bus
);

  localparam int         DATA_W   = 8;
  localparam logic [4:0] TO_EDGES = 5'(TIMEOUT);
  localparam logic [1:0] OP_WR    = 2'b00;
  localparam logic [1:0] OP_RD    = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    RMW_WR  = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                bus_en_q, bus_en_d;
  logic                bus_we_n_q, bus_we_n_d;
  logic [2:0]          bus_a_q, bus_a_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                hit_q, hit_d;

  // Command context and captured read data; only meaningful once loaded.
  logic [1:0]          op_q, op_d;
  logic [2:0]          addr_q, addr_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;

  logic [DATA_W-1:0]   rd_val;
  logic [4:0]          cnt_nx;

  // Read-modify-write result for set-bits (OR) and clear-bits (AND-NOT).
  function automatic logic [DATA_W-1:0] rmw_value(input logic [1:0]        op,
                                                  input logic [DATA_W-1:0] rdata,
                                                  input logic [DATA_W-1:0] mask);
    rmw_value = (op == OP_SET) ? (rdata | mask) : (rdata & ~mask);
  endfunction

  // Next-state, next-output and data-capture decode.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    bus_en_d    = 1'b0;
    bus_we_n_d  = 1'b1;
    bus_a_d     = 3'd0;
    bus_wdata_d = '0;
    cnt_d       = cnt_q;
    hit_d       = hit_q;
    op_d        = op_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    rbuf_d      = rbuf_q;
    rd_val      = hit_q ? rbuf_q : bus.bus_rdata;
    cnt_nx      = {1'b0, cnt_q} + 5'd1;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d        = bus.cmd_op;
          addr_d      = bus.cmd_addr;
          mask_d      = bus.cmd_data;
          cmd_ready_d = 1'b0;
          cnt_d       = 4'd0;
          hit_d       = 1'b0;
          bus_en_d    = 1'b1;
          bus_a_d     = bus.cmd_addr;
          if (bus.cmd_op == OP_WR) begin
            state_d     = WR;
            bus_we_n_d  = 1'b0;
            bus_wdata_d = bus.cmd_data;
          end else begin
            state_d = RD;
          end
        end
      end

      WR: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = mask_q;
        rsp_err_d   = 1'b0;
      end

      // Strobe ends on this edge: first bus_oe sample, first counted edge.
      RD: begin
        cnt_d = 4'd1;
        if (bus.bus_oe) begin
          hit_d  = 1'b1;
          rbuf_d = bus.bus_rdata;
        end
        if (!bus.bus_oe && TO_EDGES == 5'd1) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          cnt_d       = 4'd0;
        end else begin
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (hit_q || bus.bus_oe) begin
          if (op_q == OP_RD) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_val;
            rsp_err_d   = 1'b0;
          end else begin
            state_d     = RMW_WR;
            rbuf_d      = rmw_value(op_q, rd_val, mask_q);
            bus_en_d    = 1'b1;
            bus_we_n_d  = 1'b0;
            bus_a_d     = addr_q;
            bus_wdata_d = rmw_value(op_q, rd_val, mask_q);
          end
          cnt_d = 4'd0;
        end else if (cnt_nx >= TO_EDGES) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          cnt_d       = 4'd0;
        end else begin
          cnt_d = cnt_nx[3:0];
        end
      end

      RMW_WR: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = rbuf_q;
        rsp_err_d   = 1'b0;
      end

      RSP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Control state and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      bus_en_q    <= 1'b0;
      bus_we_n_q  <= 1'b1;
      bus_a_q     <= 3'd0;
      bus_wdata_q <= '0;
      cnt_q       <= 4'd0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      bus_en_q    <= bus_en_d;
      bus_we_n_q  <= bus_we_n_d;
      bus_a_q     <= bus_a_d;
      bus_wdata_q <= bus_wdata_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
    end
  end

  // Command context and read buffer; loaded before any use, so no reset.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    addr_q <= addr_d;
    mask_q <= mask_d;
    rbuf_q <= rbuf_d;
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.bus_en    = bus_en_q;
  assign bus.bus_we_n  = bus_we_n_q;
  assign bus.bus_a     = bus_a_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: a register-file responder with programmable
// read-data delay, directed and random commands, and a transaction-level
// model of expected latency, data, error flag and strobe sequence.
module tb_io_bus_master;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  io_bus_master_if ifc();

  io_bus_master #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Responder storage and the model's expectation of it.
  logic [7:0] rmem [8] = '{8'h5A, 8'h11, 8'h22, 8'h30, 8'h44, 8'h55, 8'h66, 8'h77};
  logic [7:0] mmem [8] = '{8'h5A, 8'h11, 8'h22, 8'h30, 8'h44, 8'h55, 8'h66, 8'h77};

  int         rd_delay = 0;
  int         oe_cnt   = -1;
  logic [2:0] rd_addr  = 3'd0;
  bit         noise    = 1'b0;
  bit         mon_on   = 1'b0;
  logic [11:0] st_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responder: samples the strobe on the falling edge; addresses 4..7 never
  // return read data. Read data appears rd_delay cycles after the strobe.
  always @(negedge clk) begin
    if (ifc.bus_en && !ifc.bus_we_n) rmem[ifc.bus_a] = ifc.bus_wdata;
    if (ifc.bus_en && ifc.bus_we_n && !ifc.bus_a[2]) begin
      oe_cnt  = rd_delay;
      rd_addr = ifc.bus_a;
    end
    if (oe_cnt == 0) begin
      ifc.bus_oe    = 1'b1;
      ifc.bus_rdata = rmem[rd_addr];
    end else if (noise) begin
      ifc.bus_oe    = ($urandom_range(0, 1) == 1);
      ifc.bus_rdata = 8'($urandom);
    end else begin
      ifc.bus_oe    = 1'b0;
      ifc.bus_rdata = 8'($urandom);
    end
    if (oe_cnt >= 0) oe_cnt--;
  end

  // Strobe recorder and idle-value monitor.
  always @(negedge clk) begin
    if (mon_on) begin
      if (ifc.bus_en) st_q.push_back({ifc.bus_we_n, ifc.bus_a, ifc.bus_wdata});
      else chk("bus_idle", {20'd0, ifc.bus_we_n, ifc.bus_a, ifc.bus_wdata}, {20'd0, 1'b1, 3'd0, 8'h00});
    end
  end

  task automatic do_cmd(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] data,
                        input int dly, input int stall);
    logic [7:0]  rv, v, exp_d;
    logic        exp_e;
    int          exp_lat, k, oe_edge;
    logic [11:0] exp_st[$];
    oe_edge = 1 + dly;

    k = 0;
    @(negedge clk);
    while (!ifc.cmd_ready && k < 20) begin @(negedge clk); k++; end
    chk("cmd_ready_idle", ifc.cmd_ready, 1);
    rd_delay = dly;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_addr  = addr;
    ifc.cmd_data  = data;
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
    st_q.delete();

    if (op == 2'b00) begin
      exp_lat = 1; exp_d = data; exp_e = 1'b0;
      mmem[addr] = data;
      exp_st.push_back({1'b0, addr, data});
    end else if (!addr[2] && oe_edge <= TO) begin
      rv = mmem[addr];
      exp_lat = (oe_edge < 2) ? 2 : oe_edge;
      exp_e = 1'b0;
      exp_st.push_back({1'b1, addr, 8'h00});
      if (op == 2'b01) begin
        exp_d = rv;
      end else begin
        v = (op == 2'b10) ? (rv | data) : (rv & ~data);
        exp_d = v;
        exp_lat++;
        mmem[addr] = v;
        exp_st.push_back({1'b0, addr, v});
      end
    end else begin
      exp_lat = TO; exp_d = 8'h00; exp_e = 1'b1;
      exp_st.push_back({1'b1, addr, 8'h00});
    end

    k = 0;
    @(negedge clk);
    while (!ifc.rsp_valid && k < 40) begin @(posedge clk); k++; @(negedge clk); end
    chk("latency", k, exp_lat);
    chk("rsp_data", ifc.rsp_data, exp_d);
    chk("rsp_err", ifc.rsp_err, exp_e);
    chk("cmd_ready_busy", ifc.cmd_ready, 0);
    chk("strobe_count", st_q.size(), exp_st.size());
    for (int i = 0; i < exp_st.size() && i < st_q.size(); i++) begin
      chk("strobe_ctl", st_q[i][11:8], exp_st[i][11:8]);
      if (!exp_st[i][11]) chk("strobe_wdata", st_q[i][7:0], exp_st[i][7:0]);
    end

    noise = 1'b1;
    for (int s = 0; s < stall; s++) begin
      ifc.cmd_valid = 1'b1;
      ifc.cmd_op    = 2'b00;
      ifc.cmd_addr  = 3'd7;
      @(negedge clk);
      chk("stall_valid", ifc.rsp_valid, 1);
      chk("stall_data", ifc.rsp_data, exp_d);
      chk("stall_err", ifc.rsp_err, exp_e);
      chk("stall_cmd_ready", ifc.cmd_ready, 0);
    end
    ifc.cmd_valid = 1'b0;
    noise = 1'b0;
    chk("stall_no_strobe", st_q.size(), exp_st.size());

    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.rsp_ready = 1'b0;
    chk("rsp_drop", ifc.rsp_valid, 0);
    chk("cmd_ready_back", ifc.cmd_ready, 1);
  endtask

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 2'b00;
    ifc.cmd_addr  = 3'd0;
    ifc.cmd_data  = 8'h00;
    ifc.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", ifc.rsp_valid, 0);
    chk("rst_bus_en", ifc.bus_en, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", ifc.cmd_ready, 1);
    chk("rst_rsp_data", ifc.rsp_data, 8'h00);
    chk("rst_rsp_err", ifc.rsp_err, 0);
    chk("rst_bus_idle", {ifc.bus_en, ifc.bus_we_n, ifc.bus_a, ifc.bus_wdata}, {1'b0, 1'b1, 3'd0, 8'h00});
    mon_on = 1'b1;

    // Directed cases
    do_cmd(2'b00, 3'd1, 8'hF0, 0, 0);
    do_cmd(2'b01, 3'd0, 8'h00, 0, 0);
    do_cmd(2'b01, 3'd4, 8'h00, 0, 0);
    do_cmd(2'b10, 3'd3, 8'h0F, 0, 0);
    do_cmd(2'b11, 3'd3, 8'h10, 0, 0);
    do_cmd(2'b01, 3'd2, 8'h00, 2, 5);
    do_cmd(2'b01, 3'd1, 8'h00, 3, 0);
    do_cmd(2'b01, 3'd1, 8'h00, 4, 1);
    do_cmd(2'b10, 3'd5, 8'hFF, 0, 0);
    do_cmd(2'b11, 3'd2, 8'h02, 4, 0);
    do_cmd(2'b10, 3'd2, 8'h81, 3, 2);
    do_cmd(2'b00, 3'd6, 8'hA5, 0, 0);
    do_cmd(2'b01, 3'd6, 8'h00, 0, 0);

    // Random commands
    for (int n = 0; n < 40; n++) begin
      do_cmd(2'($urandom), 3'($urandom), 8'($urandom),
             $urandom_range(0, 5), $urandom_range(0, 3));
    end

    // Reset during a write strobe: strobe must vanish at once, no write lands
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = 2'b00;
    ifc.cmd_addr  = 3'd2;
    ifc.cmd_data  = 8'hC3;
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
    chk("strobe_before_rst", ifc.bus_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("bus_en_async", ifc.bus_en, 0);
    chk("rsp_in_rst", ifc.rsp_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rsp_quiet_a", ifc.rsp_valid, 0);
      chk("cmd_ready_rel_a", ifc.cmd_ready, 1);
    end

    // Reset during the read wait of a set-bits command
    rd_delay = 3;
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = 2'b10;
    ifc.cmd_addr  = 3'd1;
    ifc.cmd_data  = 8'h80;
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
    st_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("bus_en_rst_wait", ifc.bus_en, 0);
    chk("rsp_rst_wait", ifc.rsp_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rsp_quiet_b", ifc.rsp_valid, 0);
      chk("cmd_ready_rel_b", ifc.cmd_ready, 1);
    end
    chk("rmw_abort_strobes", st_q.size(), 1);

    // Recovery after reset, and unchanged register contents
    do_cmd(2'b01, 3'd1, 8'h00, 0, 0);
    do_cmd(2'b01, 3'd2, 8'h00, 1, 0);
    for (int a = 0; a < 8; a++) chk("final_mem", rmem[a], mmem[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 4, SHALL set the maximum number of clk rising edges (1..15) the block waits for bus_oe after a read strobe.
REQ-002 clk  in  1  single clock; all block state SHALL update on the rising edge.
REQ-003 rst_n  in  1  reset; SHALL be asynchronous and active-low.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accept; SHALL be high only in IDLE.
REQ-006 cmd_op  in  2  opcode: 00 write, 01 read, 10 set-bits (RMW OR), 11 clear-bits (RMW AND-NOT).
REQ-007 cmd_addr  in  3  register address.
REQ-008 cmd_data  in  8  write data, or bit mask for RMW ops.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  response consumed.
REQ-011 rsp_data  out  8  read value, written value, or post-RMW value.
REQ-012 rsp_err  out  1  read timed out.
REQ-013 bus_en  out  1  register-port select strobe (to responder enable).
REQ-014 bus_we_n  out  1  0 = write, 1 = read.
REQ-015 bus_a  out  3  register address to responder.
REQ-016 bus_wdata  out  8  write data to responder DI.
REQ-017 bus_rdata  in  8  responder DO.
REQ-018 bus_oe  in  1  responder read-data valid.

Function
REQ-019 States SHALL be IDLE, WR, RD, RD_WAIT, RMW_WR, RSP.
REQ-020 A command SHALL be accepted on the rising edge where cmd_valid and cmd_ready are both high; op/addr/data are latched then.
REQ-021 Bus idle values SHALL be bus_en=0, bus_we_n=1, bus_a=0, bus_wdata=0x00, in every cycle without a strobe.
REQ-022 Each bus strobe SHALL last exactly one clk cycle, starting the cycle after the transition into WR, RD or RMW_WR; the responder samples on the intervening falling edge.
REQ-023 Write (00): strobe with bus_we_n=0, bus_a=addr, bus_wdata=data; at the following rising edge enter RSP with rsp_data=data, rsp_err=0.
REQ-024 Read (01): strobe with bus_we_n=1; bus_oe/bus_rdata SHALL be sampled on each rising edge starting at strobe end; first edge with bus_oe=1 captures bus_rdata into rsp_data, rsp_err=0.
REQ-025 If bus_oe is not seen within TIMEOUT edges (counted from strobe end, 4-bit counter) the block SHALL enter RSP with rsp_data=0x00, rsp_err=1.
REQ-026 RMW (10/11): perform the read as REQ-024; on capture, compute v=rdata|mask (10) or rdata&~mask (11) and issue a write strobe of v to the same address in the next cycle, then RSP with rsp_data=v, rsp_err=0.
REQ-027 RMW read timeout SHALL skip the write strobe and respond as REQ-025.
REQ-028 rsp_valid SHALL be high exactly in RSP; rsp_data/rsp_err SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-029 On rising edge with rsp_valid and rsp_ready, return to IDLE; cmd_ready rises in the following cycle (no same-edge command acceptance).
REQ-030 Writes to any address, including bus_a[2]=1, SHALL complete without error; no write acknowledge exists.
REQ-031 Minimum latency acceptance→rsp_valid: write 1 edge, read 2 edges, RMW 3 edges.
REQ-032 bus_oe seen outside RD/RD_WAIT SHALL be ignored.

Reset
REQ-033 While rst_n=0: state IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_data=0x00, rsp_err=0, bus outputs at idle values, timeout counter 0.
REQ-034 Reset asserted mid-transaction SHALL abort it immediately (bus_en drops asynchronously), and no response SHALL be produced.

Verification
REQ-035 Write op=00 addr=1 data=0xF0 -> one-cycle strobe bus_en=1, bus_we_n=0, bus_a=1, bus_wdata=0xF0; rsp_valid next edge, rsp_data=0xF0, rsp_err=0.
REQ-036 Read op=01 addr=0, responder returns OE=1 DO=0x5A -> rsp_data=0x5A, rsp_err=0, rsp_valid 2 edges after acceptance.
REQ-037 Read addr=4 (responder never asserts OE), TIMEOUT=4 -> rsp_valid after 4 wait edges, rsp_data=0x00, rsp_err=1.
REQ-038 Set-bits op=10 addr=3 mask=0x0F, DDRB reads 0x30 -> second strobe writes 0x3F, rsp_data=0x3F; clear-bits mask=0x10 on 0x3F -> writes 0x2F.
REQ-039 rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, no bus strobe; rsp_ready high -> IDLE, cmd_ready=1 next cycle.
REQ-040 rst_n low during RMW read wait -> bus_en=0 immediately, rsp_valid stays 0, cmd_ready=1 after release.
